control_unit: RTL
=================

// Module: control_unit
// PURPOSE
//  Multi-cycle accumulator sequencer for the 16-bit Von Neumann processor; the producer side of the ALU interface.
//  Fetches 16-bit instructions and operands from one shared memory port, drives ALU opcode/operands, and latches
//  result + zero flag. Holds PC, IR, MDR, ACC and the Z flag; the top level wires it between the ALU and unified RAM.
// PARAMETERS
//  ADDR_W    12   memory address width; instruction = {opcode[3:0], addr[ADDR_W-1:0]}
//  DATA_W    16   word width; must equal 4+ADDR_W
//  RESET_PC  0    PC value loaded on reset
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       synchronous, active-high reset
//  mem_addr     out  ADDR_W  shared instruction/data address
//  mem_re       out  1       read strobe; data valid on mem_rdata the NEXT cycle
//  mem_we       out  1       write strobe; mem_wdata written at this clock edge
//  mem_wdata    out  DATA_W  store data (= ACC)
//  mem_rdata    in   DATA_W  synchronous-read data
//  alu_opcode   out  4       ALU op: 0001 ADD,0010 SUB,0011 AND,0100 OR,0101 XOR,0110 NOT; 0000 when idle
//  alu_a        out  DATA_W  = ACC
//  alu_b        out  DATA_W  = MDR
//  alu_result   in   DATA_W  ALU result (combinational)
//  alu_zero     in   1       ALU zero flag
//  acc_out      out  DATA_W  accumulator (debug/observe)
//  pc_out       out  ADDR_W  program counter
//  halted       out  1       high in HALT state
// BEHAVIOUR
//  Opcodes [15:12]: 0000 NOP, 0001-0101 ALU op ACC=ACC op M[a], 0110 NOT ACC=~ACC, 0111 LOAD ACC=M[a],
//   1000 STORE M[a]=ACC, 1001 JMP PC=a, 1010 JZ if Z PC=a, 1111 HALT; 1011-1110 undefined -> NOP.
//  Reset (sync): state=FETCH, PC=RESET_PC, IR=MDR=ACC=0, Z=0. All outputs Moore (decoded from state/regs), so in the
//   first cycle after reset: mem_re=1, mem_addr=RESET_PC, mem_we=0, alu_opcode=0, halted=0. rst wins over every state.
//  FSM:
//   FETCH      mem_addr=PC, mem_re=1 -> FETCH_WAIT
//   FETCH_WAIT IR<=mem_rdata, PC<=PC+1 (wraps max->0) -> DECODE
//   DECODE     ALU-mem op/LOAD: mem_addr=IR[a], mem_re=1 -> OP_WAIT; NOT -> EXECUTE; STORE -> STORE;
//              JMP: PC<=a -> FETCH; JZ: PC<=a only if Z=1 -> FETCH; NOP/undefined -> FETCH; HALT -> HALT
//   OP_WAIT    MDR<=mem_rdata -> EXECUTE
//   EXECUTE    alu_opcode=IR[15:12] (LOAD: alu_opcode=0); ACC<=alu_result, Z<=alu_zero;
//              LOAD: ACC<=MDR, Z<=(MDR==0) -> FETCH
//   STORE      mem_addr=a, mem_wdata=ACC, mem_we=1 -> FETCH (Z unchanged)
//   HALT       all strobes 0, halted=1; exits only via rst
//  Cycles/instr: ALU-mem op and LOAD 5; NOT and STORE 4; JMP, JZ, NOP, undefined 3.
//  mem_re and mem_we never both high. Arithmetic is DATA_W modulo; no carry/overflow kept.
//  Z is updated only in EXECUTE; JMP/JZ/NOP/STORE preserve it. alu_opcode=0000 outside EXECUTE.
// TESTING  (bench: 4096x16 sync-read RAM + ALU instance; a=operand address)
//  1 rst high 2 cycles -> pc_out=0, acc_out=0, halted=0, mem_we=0; first cycle after release mem_re=1, mem_addr=0.
//  2 M[0..3]=7100,1101,8102,F000; M[100]=9, M[101]=3 -> M[102]=12, acc_out=12, halted=1 after 5+5+4+3=17 cycles.
//  3 LOAD 5, SUB 5 -> acc=0, Z=1, JZ 010 -> next fetch addr 010; repeat with 6-5 -> JZ not taken, fetch PC+1.
//  4 ACC=000F: AND 7->0007, OR 7->000F, XOR 7->0008; ACC=F000 NOT->0FFF; ACC=FFFF ADD 1->0000, Z=1.
//  5 M[0]=B123 -> ACC, Z and RAM unchanged, next fetch addr 1; JMP FFF with NOP at FFF -> next fetch addr 000.
//  6 rst during OP_WAIT -> next cycle FETCH at addr 0, acc=0; after HALT, 20 cycles with mem_re=mem_we=0, pc stable.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle accumulator sequencer for the 16-bit Von Neumann processor.
// Fetches instructions and operands through one shared synchronous-read memory
// port, drives the ALU from ACC/MDR and latches its result and zero flag.
// All outputs are Moore: decoded from the state and the architectural registers.
module control_unit #(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted
);

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_NOT   = 4'b0110;
  localparam logic [3:0] OP_LOAD  = 4'b0111;
  localparam logic [3:0] OP_STORE = 4'b1000;
  localparam logic [3:0] OP_JMP   = 4'b1001;
  localparam logic [3:0] OP_JZ    = 4'b1010;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  typedef enum logic [2:0] {
    S_FETCH, S_FETCH_WAIT, S_DECODE, S_OP_WAIT, S_EXECUTE, S_STORE, S_HALT
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [DATA_W-1:0] ir_reg, ir_next;
  logic [DATA_W-1:0] mdr_reg, mdr_next;
  logic [DATA_W-1:0] acc_reg, acc_next;
  logic              z_reg, z_next;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand_addr;
  logic              reads_mem;

  assign opcode       = ir_reg[DATA_W-1 -: 4];
  assign operand_addr = ir_reg[ADDR_W-1:0];
  // Two-operand ALU ops and LOAD need M[a] in MDR before EXECUTE.
  assign reads_mem    = ((opcode >= OP_ADD) && (opcode <= OP_XOR)) || (opcode == OP_LOAD);

  // State and architectural register update; reset overrides every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
      pc_reg    <= RESET_PC;
      ir_reg    <= '0;
      mdr_reg   <= '0;
      acc_reg   <= '0;
      z_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      mdr_reg   <= mdr_next;
      acc_reg   <= acc_next;
      z_reg     <= z_next;
    end
  end

  // Next-state and register-next logic for the instruction sequence.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    mdr_next   = mdr_reg;
    acc_next   = acc_reg;
    z_next     = z_reg;
    case (state_reg)
      S_FETCH: state_next = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        ir_next    = mem_rdata;
        pc_next    = pc_reg + 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        state_next = S_FETCH;
        if (reads_mem) begin
          state_next = S_OP_WAIT;
        end else begin
          case (opcode)
            OP_NOT:   state_next = S_EXECUTE;
            OP_STORE: state_next = S_STORE;
            OP_JMP:   pc_next = operand_addr;
            OP_JZ:    if (z_reg) pc_next = operand_addr;
            OP_HALT:  state_next = S_HALT;
            default:  state_next = S_FETCH;
          endcase
        end
      end
      S_OP_WAIT: begin
        mdr_next   = mem_rdata;
        state_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (opcode == OP_LOAD) begin
          acc_next = mdr_reg;
          z_next   = (mdr_reg == '0);
        end else begin
          acc_next = alu_result;
          z_next   = alu_zero;
        end
        state_next = S_FETCH;
      end
      S_STORE: state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  // Moore output decode; the address bus idles on PC when not otherwise used.
  always_comb begin
    mem_addr   = pc_reg;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    alu_opcode = 4'b0000;
    halted     = 1'b0;
    case (state_reg)
      S_FETCH: mem_re = 1'b1;
      S_DECODE: begin
        if (reads_mem) begin
          mem_re   = 1'b1;
          mem_addr = operand_addr;
        end
      end
      S_EXECUTE: alu_opcode = (opcode == OP_LOAD) ? 4'b0000 : opcode;
      S_STORE: begin
        mem_we   = 1'b1;
        mem_addr = operand_addr;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign mem_wdata = acc_reg;
  assign alu_a     = acc_reg;
  assign alu_b     = mdr_reg;
  assign acc_out   = acc_reg;
  assign pc_out    = pc_reg;

endmodule
